// File: rtl/input_cond_pkg.sv
// Shared edge-mode constants and helpers for the input conditioner.
// The optional auto-repeat feature is selected with INPUT_COND_REPEAT_EN.
package input_cond_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/input_cond_ch.sv
// One conditioner channel: two-flop sync, counter debounce, edge pulse and,
// when INPUT_COND_REPEAT_EN is defined, auto-repeat while the level is held.
module input_cond_ch
  import input_cond_pkg::*;
#(
  parameter int         DB_CYCLES     = 1000000,
  parameter edge_mode_t EDGE          = EDGE_RISE,
  parameter int         REPEAT_DELAY  = 50000000,
  parameter int         REPEAT_PERIOD = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int              CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          differ;
  logic          accept;
  logic          rise;
  logic          fall;
  logic          edge_hit;
  logic          rpt_hit;

  // A new level is accepted only after DB_CYCLES consecutive differing samples.
  assign differ = s2 ^ level;
  assign accept = differ && (cnt == CNT_LAST);
  assign rise   = accept && !level;
  assign fall   = accept && level;

  always_comb begin
    edge_hit = 1'b0;
    case (EDGE)
      EDGE_RISE: edge_hit = rise;
      EDGE_FALL: edge_hit = fall;
      EDGE_BOTH: edge_hit = accept;
      default:   edge_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      pulse <= edge_hit | rpt_hit;
      if (!differ || accept) cnt <= '0;
      else                   cnt <= cnt + CW'(1);
      if (accept) level <= ~level;
    end
  end

`ifdef INPUT_COND_REPEAT_EN
  localparam int            RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [RW-1:0] RPT_FIRST_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_NEXT_LAST  = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_first;
  logic [RW-1:0] rpt_target;

  // The counter restarts on the rising edge so the first repeat lands
  // REPEAT_DELAY cycles after level rose; a falling edge suppresses it.
  assign rpt_target = rpt_first ? RPT_FIRST_LAST : RPT_NEXT_LAST;
  assign rpt_hit    = level && !fall && (rpt_cnt == rpt_target);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (!level || fall) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (rpt_hit) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b0;
    end else begin
      rpt_cnt <= rpt_cnt + RW'(1);
    end
  end
`else
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign rpt_hit        = 1'b0;
`endif

  a_cnt_bounded: assert property (@(posedge clk) disable iff (rst) cnt <= CNT_LAST);

endmodule

// File: rtl/input_conditioner.sv
// N-channel switch/button conditioner built from independent input_cond_ch
// copies. Auto-repeat is compiled in only with INPUT_COND_REPEAT_EN.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int         N             = 20,
  parameter int         DB_CYCLES     = 1000000,
  parameter edge_mode_t EDGE          = EDGE_RISE,
  parameter int         REPEAT_DELAY  = 50000000,
  parameter int         REPEAT_PERIOD = 10000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] raw,
  output logic [N-1:0] level,
  output logic [N-1:0] pulse
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    input_cond_ch #(
      .DB_CYCLES    (DB_CYCLES),
      .EDGE         (EDGE),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw[i]),
      .level(level[i]),
      .pulse(pulse[i])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: one instance per edge mode, all fed
// from the same raw vector, checked against hand-computed cycle timings.
module tb_input_conditioner;
  import input_cond_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] raw;
  logic [N-1:0] level_r, pulse_r;
  logic [N-1:0] level_f, pulse_f;
  logic [N-1:0] level_b, pulse_b;

  int n_checks = 0;
  int n_fail   = 0;

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (checks=%0d)", n_checks);
    $fatal(1);
  end

  input_conditioner #(.N(N), .DB_CYCLES(4), .EDGE(EDGE_RISE),
                      .REPEAT_DELAY(8), .REPEAT_PERIOD(3)) dut_rise (
    .clk(clk), .rst(rst), .raw(raw), .level(level_r), .pulse(pulse_r));

  input_conditioner #(.N(N), .DB_CYCLES(4), .EDGE(EDGE_FALL),
                      .REPEAT_DELAY(8), .REPEAT_PERIOD(3)) dut_fall (
    .clk(clk), .rst(rst), .raw(raw), .level(level_f), .pulse(pulse_f));

  input_conditioner #(.N(N), .DB_CYCLES(4), .EDGE(EDGE_BOTH),
                      .REPEAT_DELAY(8), .REPEAT_PERIOD(3)) dut_both (
    .clk(clk), .rst(rst), .raw(raw), .level(level_b), .pulse(pulse_b));

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Advance one active edge and return on the following falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    int bad;
    int npulse;
    logic exp_p;
    logic exp_l;

    raw = '0;
    rst = 1'b1;
    step(2);
    check("reset_level", level_r, 4'b0000);
    check("reset_pulse", pulse_r, 4'b0000);
    rst = 1'b0;

    // Clean press then release on channel 0.
    raw = 4'b0001;
    step(5);
    check("t1_level_before", level_r, 4'b0000);
    step(1);
    check("t1_level_rise", level_r, 4'b0001);
    check("t1_pulse_rise", pulse_r, 4'b0001);
    check("t1_pulse_fall_mode", pulse_f, 4'b0000);
    check("t1_pulse_both_mode", pulse_b, 4'b0001);
    step(1);
    check("t1_pulse_clear", pulse_r, 4'b0000);
    check("t1_level_hold", level_r, 4'b0001);
    raw = 4'b0000;
    step(5);
    check("t1_level_before_fall", level_r, 4'b0001);
    step(1);
    check("t1_level_fall", level_r, 4'b0000);
    check("t1_rise_mode_no_pulse", pulse_r, 4'b0000);
    check("t1_fall_mode_pulse", pulse_f, 4'b0001);
    check("t1_both_mode_pulse", pulse_b, 4'b0001);
    step(1);
    check("t1_fall_pulse_clear", pulse_f, 4'b0000);
    check("t1_both_pulse_clear", pulse_b, 4'b0000);

    // Bounce on channel 1: highs of 2 cycles must never be accepted.
    bad = 0;
    for (int b = 0; b < 4; b++) begin
      raw[1] = (b % 2 == 0);
      for (int c = 0; c < 2; c++) begin
        step(1);
        if (level_r[1] || pulse_r[1] || pulse_b[1]) bad++;
      end
    end
    raw[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step(1);
      if (level_r[1] || pulse_r[1] || pulse_b[1]) bad++;
    end
    check("t2_bounce_quiet", bad, 0);
    step(1);
    check("t2_level_rise", level_r, 4'b0010);
    check("t2_pulse_rise", pulse_r, 4'b0010);
    raw = 4'b0000;
    step(8);
    check("t2_level_released", level_r, 4'b0000);

    // All channels together, then async reset while level/pulse are high.
    raw = 4'b1111;
    step(5);
    check("t3_level_before", level_r, 4'b0000);
    step(1);
    check("t3_pulse_all", pulse_r, 4'b1111);
    check("t3_pulse_all_both", pulse_b, 4'b1111);
    check("t3_pulse_none_fall", pulse_f, 4'b0000);
    #2;
    rst = 1'b1;
    #1;
    check("t3_async_level", level_r, 4'b0000);
    check("t3_async_pulse", pulse_r, 4'b0000);
    check("t3_async_level_both", level_b, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    check("t3_reset_hold", level_r, 4'b0000);
    rst = 1'b0;
    step(5);
    check("t3_level_before_rerise", level_r, 4'b0000);
    step(1);
    check("t3_level_rerise", level_r, 4'b1111);
    check("t3_pulse_rerise", pulse_r, 4'b1111);
    raw = 4'b0000;
    step(8);
    check("t3_level_released", level_r, 4'b0000);

    // Long hold on channel 2; repeats only exist with the macro defined.
    raw = 4'b0100;
    step(5);
    check("t4_level_before", level_r, 4'b0000);
    step(1);
    check("t4_pulse_rise", pulse_r, 4'b0100);
    npulse = 1;
    for (int j = 1; j <= 45; j++) begin
      if (j == 31) raw = 4'b0000;
      step(1);
`ifdef INPUT_COND_REPEAT_EN
      exp_p = (j >= 8) && (j < 36) && ((j - 8) % 3 == 0);
`else
      exp_p = 1'b0;
`endif
      exp_l = (j < 36);
      check($sformatf("t4_pulse_j%0d", j), pulse_r[2], exp_p);
      check($sformatf("t4_level_j%0d", j), level_r[2], exp_l);
      if (pulse_r[2]) npulse++;
    end
`ifdef INPUT_COND_REPEAT_EN
    check("t4_pulse_total", npulse, 11);
`else
    check("t4_pulse_total", npulse, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
